// File: rtl/fork_join_ctrl.sv
// Fork/join controller: launches up to NUM_CH timed channels and joins on ALL, ANY or NONE.
// Optional FJ_DISABLE_FORK_EN adds a disable_fork input that aborts every channel and the pending join.
module fork_join_ctrl #(
  parameter int NUM_CH = 4,
  parameter int DUR_W  = 8
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start,
  input  logic [1:0]                mode,
  input  logic [NUM_CH-1:0]         ch_en,
  input  logic [NUM_CH*DUR_W-1:0]   dur,
`ifdef FJ_DISABLE_FORK_EN
  input  logic                      disable_fork,
  output logic                      aborted,
`endif
  output logic                      busy,
  output logic                      join_done,
  output logic [NUM_CH-1:0]         ch_active,
  output logic [NUM_CH-1:0]         ch_done,
  output logic [$clog2(NUM_CH)-1:0] first_id
);

  localparam int ID_W = $clog2(NUM_CH);

  typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

  state_t            state, state_nxt;
  logic [NUM_CH-1:0] pend, pend_nxt;
  logic [NUM_CH-1:0] launch, hit, left;
  logic              any_q, any_nxt;
  logic              join_nxt;
  logic [ID_W-1:0]   id_nxt;
  logic              dis;
  logic [DUR_W-1:0]  cnt [NUM_CH];

`ifdef FJ_DISABLE_FORK_EN
  logic abort_nxt;
  assign dis = disable_fork;
`else
  assign dis = 1'b0;
`endif

  assign busy = (state == WAIT);

  // A channel finishes in the cycle its counter reads zero while still active.
  always_comb begin
    ch_done = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      ch_done[i] = ch_active[i] && (cnt[i] == '0);
    end
  end

  always_comb begin
    state_nxt = state;
    pend_nxt  = pend;
    any_nxt   = any_q;
    join_nxt  = 1'b0;
    id_nxt    = first_id;
    launch    = '0;
    hit       = pend & ch_done;
    left      = pend & ~ch_done;
`ifdef FJ_DISABLE_FORK_EN
    abort_nxt = 1'b0;
`endif
    if (dis) begin
      state_nxt = IDLE;
      pend_nxt  = '0;
`ifdef FJ_DISABLE_FORK_EN
      abort_nxt = (state == WAIT);
`endif
    end else if (state == IDLE) begin
      if (start) begin
        // Channels still running from an earlier fork are left alone and excluded from this join.
        launch = ch_en & ~ch_active;
        if (launch == '0 || mode == 2'b10) begin
          join_nxt = 1'b1;
        end else begin
          state_nxt = WAIT;
          pend_nxt  = launch;
          any_nxt   = (mode == 2'b01);
        end
      end
    end else begin
      if (any_q) begin
        if (hit != '0) begin
          join_nxt  = 1'b1;
          state_nxt = IDLE;
          pend_nxt  = '0;
          for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (hit[i]) id_nxt = ID_W'(i);
          end
        end
      end else begin
        pend_nxt = left;
        if (left == '0) begin
          join_nxt  = 1'b1;
          state_nxt = IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      pend      <= '0;
      any_q     <= 1'b0;
      join_done <= 1'b0;
      first_id  <= '0;
`ifdef FJ_DISABLE_FORK_EN
      aborted   <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      pend      <= pend_nxt;
      any_q     <= any_nxt;
      join_done <= join_nxt;
      first_id  <= id_nxt;
`ifdef FJ_DISABLE_FORK_EN
      aborted   <= abort_nxt;
`endif
    end
  end

  // Counter loads D-1 so a zero duration still gives one active cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ch_active <= '0;
      for (int i = 0; i < NUM_CH; i++) cnt[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (dis) begin
          ch_active[i] <= 1'b0;
          cnt[i]       <= '0;
        end else if (launch[i]) begin
          ch_active[i] <= 1'b1;
          cnt[i]       <= (dur[i*DUR_W +: DUR_W] == '0) ? '0
                                                        : dur[i*DUR_W +: DUR_W] - DUR_W'(1);
        end else if (ch_active[i]) begin
          if (cnt[i] == '0) ch_active[i] <= 1'b0;
          else              cnt[i]       <= cnt[i] - DUR_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fork_join_ctrl.sv
// Directed bench for fork_join_ctrl: ALL/ANY/NONE joins, boundaries, back-to-back forks and reset.
module tb_fork_join_ctrl;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [1:0]  mode = 2'b00;
  logic [3:0]  ch_en = 4'b0000;
  logic [31:0] dur = '0;
  logic        busy, join_done;
  logic [3:0]  ch_active, ch_done;
  logic [1:0]  first_id;
`ifdef FJ_DISABLE_FORK_EN
  logic        disable_fork = 1'b0;
  logic        aborted;
`endif

  int pass_cnt = 0;
  int total = 0;
  int cyc = 0;

  always #5 clk = ~clk;

  fork_join_ctrl #(.NUM_CH(4), .DUR_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .start(start),
    .mode(mode),
    .ch_en(ch_en),
    .dur(dur),
`ifdef FJ_DISABLE_FORK_EN
    .disable_fork(disable_fork),
    .aborted(aborted),
`endif
    .busy(busy),
    .join_done(join_done),
    .ch_active(ch_active),
    .ch_done(ch_done),
    .first_id(first_id)
  );

  // Advance to 1 time unit after the next rising edge; cyc then names the cycle being observed.
  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic launch_fork(input logic [1:0] m, input logic [3:0] en, input logic [31:0] d);
    mode  = m;
    ch_en = en;
    dur   = d;
    start = 1'b1;
    cyc   = 0;
    tick();
    start = 1'b0;
  endtask

  task automatic drain(output bit timed_out);
    int n;
    n = 0;
    while (ch_active != 4'b0000 && n < 400) begin
      tick();
      n++;
    end
    timed_out = (ch_active != 4'b0000);
    tick();
  endtask

  task automatic test_reset();
    #2;
    total++; if (busy !== 1'b0) $display("FAIL rst_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (join_done !== 1'b0) $display("FAIL rst_join got=%b exp=0", join_done); else pass_cnt++;
    total++; if (ch_active !== 4'b0000) $display("FAIL rst_active got=%b exp=0000", ch_active); else pass_cnt++;
    total++; if (ch_done !== 4'b0000) $display("FAIL rst_done got=%b exp=0000", ch_done); else pass_cnt++;
    total++; if (first_id !== 2'd0) $display("FAIL rst_first_id got=%0d exp=0", first_id); else pass_cnt++;
    tick();
    total++; if (busy !== 1'b0) $display("FAIL rst_busy_clk got=%b exp=0", busy); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_all();
    logic [3:0] e;
    launch_fork(2'b00, 4'b1111, {8'd40, 8'd30, 8'd20, 8'd10});
    mode = 2'b01; ch_en = 4'b0000; dur = '0;
    while (cyc <= 42) begin
      e = {cyc == 40, cyc == 30, cyc == 20, cyc == 10};
      total++; if (ch_done !== e) $display("FAIL all_ch_done cyc=%0d got=%b exp=%b", cyc, ch_done, e); else pass_cnt++;
      total++; if (join_done !== (cyc == 41)) $display("FAIL all_join cyc=%0d got=%b exp=%b", cyc, join_done, cyc == 41); else pass_cnt++;
      total++; if (busy !== (cyc >= 1 && cyc <= 40)) $display("FAIL all_busy cyc=%0d got=%b", cyc, busy); else pass_cnt++;
      tick();
    end
  endtask

  task automatic test_any();
    bit to;
    launch_fork(2'b01, 4'b1111, {8'd40, 8'd5, 8'd5, 8'd10});
    while (cyc <= 7) begin
      total++; if (join_done !== (cyc == 6)) $display("FAIL any_join cyc=%0d got=%b exp=%b", cyc, join_done, cyc == 6); else pass_cnt++;
      total++; if (busy !== (cyc <= 5)) $display("FAIL any_busy cyc=%0d got=%b exp=%b", cyc, busy, cyc <= 5); else pass_cnt++;
      if (cyc >= 6) begin
        total++; if (first_id !== 2'd1) $display("FAIL any_first_id cyc=%0d got=%0d exp=1", cyc, first_id); else pass_cnt++;
      end
      if (cyc == 7) begin
        total++; if (ch_active !== 4'b1001) $display("FAIL any_background got=%b exp=1001", ch_active); else pass_cnt++;
      end
      tick();
    end
    drain(to);
    total++; if (to) $display("FAIL any_drain got=timeout exp=idle"); else pass_cnt++;
  endtask

  task automatic test_none();
    bit to;
    launch_fork(2'b10, 4'b1111, {4{8'd100}});
    while (cyc <= 7) begin
      total++; if (join_done !== (cyc == 1 || cyc == 6)) $display("FAIL none_join cyc=%0d got=%b", cyc, join_done); else pass_cnt++;
      total++; if (busy !== 1'b0) $display("FAIL none_busy cyc=%0d got=%b exp=0", cyc, busy); else pass_cnt++;
      total++; if (ch_active !== 4'b1111) $display("FAIL none_active cyc=%0d got=%b exp=1111", cyc, ch_active); else pass_cnt++;
      if (cyc == 5) begin
        start = 1'b1; mode = 2'b00; ch_en = 4'b1111;
      end else begin
        start = 1'b0;
      end
      tick();
    end
    drain(to);
    total++; if (to) $display("FAIL none_drain got=timeout exp=idle"); else pass_cnt++;
  endtask

  task automatic test_boundary();
    int act0, act1, jc, dc0;
    act0 = 0; act1 = 0; jc = -1; dc0 = -1;
    launch_fork(2'b00, 4'b0011, {8'd0, 8'd0, 8'd255, 8'd0});
    while (cyc <= 258) begin
      if (ch_active[0]) act0++;
      if (ch_active[1]) act1++;
      if (join_done && jc < 0) jc = cyc;
      if (ch_done[0] && dc0 < 0) dc0 = cyc;
      tick();
    end
    total++; if (act0 !== 1) $display("FAIL bnd_span0 got=%0d exp=1", act0); else pass_cnt++;
    total++; if (act1 !== 255) $display("FAIL bnd_span255 got=%0d exp=255", act1); else pass_cnt++;
    total++; if (dc0 !== 1) $display("FAIL bnd_done0 got=%0d exp=1", dc0); else pass_cnt++;
    total++; if (jc !== 256) $display("FAIL bnd_join got=%0d exp=256", jc); else pass_cnt++;
    launch_fork(2'b00, 4'b0000, {4{8'd7}});
    total++; if (join_done !== 1'b1) $display("FAIL empty_join got=%b exp=1", join_done); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL empty_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (ch_active !== 4'b0000) $display("FAIL empty_active got=%b exp=0000", ch_active); else pass_cnt++;
    tick();
    total++; if (join_done !== 1'b0) $display("FAIL empty_join_pulse got=%b exp=0", join_done); else pass_cnt++;
  endtask

  task automatic test_back_to_back();
    launch_fork(2'b00, 4'b0001, {8'd9, 8'd9, 8'd9, 8'd2});
    start = 1'b1; ch_en = 4'b0100;
    tick();
    start = 1'b0;
    total++; if (ch_active !== 4'b0001) $display("FAIL b2b_wait_ignore got=%b exp=0001", ch_active); else pass_cnt++;
    total++; if (ch_done !== 4'b0001) $display("FAIL b2b_done got=%b exp=0001", ch_done); else pass_cnt++;
    tick();
    total++; if (join_done !== 1'b1) $display("FAIL b2b_join1 got=%b exp=1", join_done); else pass_cnt++;
    start = 1'b1; mode = 2'b11; ch_en = 4'b0010; dur = {8'd0, 8'd0, 8'd1, 8'd0};
    tick();
    start = 1'b0;
    total++; if (ch_active !== 4'b0010) $display("FAIL b2b_active got=%b exp=0010", ch_active); else pass_cnt++;
    total++; if (busy !== 1'b1) $display("FAIL b2b_busy got=%b exp=1", busy); else pass_cnt++;
    total++; if (ch_done !== 4'b0010) $display("FAIL b2b_done2 got=%b exp=0010", ch_done); else pass_cnt++;
    tick();
    total++; if (join_done !== 1'b1) $display("FAIL b2b_join2 got=%b exp=1", join_done); else pass_cnt++;
    total++; if (busy !== 1'b0) $display("FAIL b2b_idle got=%b exp=0", busy); else pass_cnt++;
    tick();
  endtask

  task automatic test_reset_mid();
    launch_fork(2'b00, 4'b1111, {8'd40, 8'd30, 8'd20, 8'd10});
    while (cyc < 15) tick();
    rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) $display("FAIL mid_rst_busy got=%b exp=0", busy); else pass_cnt++;
    total++; if (ch_active !== 4'b0000) $display("FAIL mid_rst_active got=%b exp=0000", ch_active); else pass_cnt++;
    total++; if (ch_done !== 4'b0000) $display("FAIL mid_rst_done got=%b exp=0000", ch_done); else pass_cnt++;
    total++; if (first_id !== 2'd0) $display("FAIL mid_rst_first_id got=%0d exp=0", first_id); else pass_cnt++;
    for (int n = 0; n < 2; n++) begin
      tick();
      total++; if (join_done !== 1'b0) $display("FAIL mid_rst_join got=%b exp=0", join_done); else pass_cnt++;
    end
    rst_n = 1'b1;
    launch_fork(2'b00, 4'b0011, {8'd0, 8'd0, 8'd2, 8'd3});
    total++; if (ch_active !== 4'b0011) $display("FAIL restart_active got=%b exp=0011", ch_active); else pass_cnt++;
    while (cyc <= 5) begin
      total++; if (join_done !== (cyc == 4)) $display("FAIL restart_join cyc=%0d got=%b exp=%b", cyc, join_done, cyc == 4); else pass_cnt++;
      tick();
    end
  endtask

`ifdef FJ_DISABLE_FORK_EN
  task automatic test_disable();
    launch_fork(2'b00, 4'b1111, {8'd40, 8'd30, 8'd20, 8'd12});
    while (cyc <= 16) begin
      total++; if (join_done !== 1'b0) $display("FAIL dis_join cyc=%0d got=%b exp=0", cyc, join_done); else pass_cnt++;
      total++; if (aborted !== (cyc == 13)) $display("FAIL dis_aborted cyc=%0d got=%b exp=%b", cyc, aborted, cyc == 13); else pass_cnt++;
      if (cyc == 12) begin
        total++; if (ch_done !== 4'b0001) $display("FAIL dis_done_same got=%b exp=0001", ch_done); else pass_cnt++;
        disable_fork = 1'b1; start = 1'b1; ch_en = 4'b1111;
      end else begin
        disable_fork = 1'b0; start = 1'b0;
      end
      if (cyc >= 13) begin
        total++; if (ch_active !== 4'b0000) $display("FAIL dis_active cyc=%0d got=%b exp=0000", cyc, ch_active); else pass_cnt++;
        total++; if (busy !== 1'b0) $display("FAIL dis_busy cyc=%0d got=%b exp=0", cyc, busy); else pass_cnt++;
      end
      tick();
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_all();
    test_any();
    test_none();
    test_boundary();
    test_back_to_back();
`ifdef FJ_DISABLE_FORK_EN
    test_disable();
`endif
    test_reset_mid();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
